array_mac_sequencer: RTL
========================

Name: array_mac_sequencer

Overview:
- Sequential controller for the element-wise multiply datapath: for every (i, j) it computes array3[i][j] = array1[i][j] * array2[j][i].
- It does not take whole arrays on wide buses. It walks the index space in row-major order and issues one operand read per cycle to external operand storage.
- It owns a single shared multiplier and streams products out over a valid/ready result interface to the array3 store.
- Sits between the operand RAMs and the result RAM; started by a host handshake.

Parameters:
- ROW, 8, number of rows (i range 0..ROW-1); must be >= 2
- COL, 4, number of columns (j range 0..COL-1); must be >= 2
- WIDTH, 10, operand element width in bits
- RW, $clog2(ROW), row index width (derived localparam)
- CW, $clog2(COL), column index width (derived localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  host requests a full pass
- start_ready  out  1  high only in IDLE
- rd_en  out  1  operand read strobe
- rd_row  out  RW  i of current read
- rd_col  out  CW  j of current read
- a_data  in  WIDTH  array1[i][j]; valid exactly 1 cycle after rd_en
- b_data  in  WIDTH  array2[j][i]; valid exactly 1 cycle after rd_en (external storage applies the transpose)
- res_valid  out  1  product available
- res_ready  in  1  downstream accepts product
- res_row  out  RW  i of product
- res_col  out  CW  j of product
- res_data  out  2*WIDTH  unsigned product a*b, full width, no truncation
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse after last product handshake

Behaviour:
- Reset: state=IDLE, all counters zero. rd_en, res_valid, busy and done are 0; start_ready=1. Index/data outputs are 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: start_valid && start_ready -> RUN on next edge; issue counters clear to (0,0).
- RUN: rd_en asserts when credit is available. Each issue advances j; at j=COL-1 it wraps to 0 and increments i. After issuing (ROW-1, COL-1) the state -> DRAIN.
- DRAIN: no reads. When the last product (ROW-1, COL-1) handshakes, go to IDLE next edge, and done=1 for that one cycle.
- Pipeline: issue at cycle t, operands at t+1, product registered into the output register at t+2.
  - With res_ready held high: start accepted at edge 0, first rd_en in cycle 1, first res_valid in cycle 3.
  - Throughput is 1 product/cycle; ROW*COL products complete in ROW*COL+3 cycles.
- Buffering: one output register plus one skid register.
  - Credit rule: outstanding = rd_pending + res_valid + skid_valid. Issue only if outstanding - (res_valid && res_ready) < 2.
  - Products are never dropped or overwritten, and order is strictly row-major.
- Backpressure: res_valid/res_row/res_col/res_data hold stable while res_valid && !res_ready.
- start_valid during RUN/DRAIN is ignored (start_ready=0); no restart mid-pass.
- Reset mid-operation: everything returns to reset values next edge. Any returning read data is discarded; no res_valid or done is produced.
- Arithmetic: unsigned, 2*WIDTH product. All-ones operands give (2^WIDTH-1)^2 exactly.

Optional Feature:
- Macro: ARRAY_MAC_ACCUM_EN.
- Defined:
  - Adds output port acc_sum, width 2*WIDTH+$clog2(ROW*COL), holding the running sum of all products accepted in the current pass.
  - Cleared on start accept and on rst; updated on each res handshake; stable from the done pulse until the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, a=i+1, b=j+1, res_ready=1 -> 32 products in row-major order with res_data=(i+1)*(j+1); first res_valid in cycle 3; done in cycle 35.
- res_ready toggled 1,0,0,1 repeating -> all 32 products delivered in order, none duplicated; outputs stable while stalled; outstanding never exceeds 2.
- a=b=1023 for all elements -> every res_data=1046529 (0xFF801).
- rst asserted mid-pass at the 10th product -> next cycle busy=0 and start_ready=1; no further res_valid; a new start runs a clean full pass from (0,0).
- start_valid held high throughout -> exactly one pass per IDLE visit; back-to-back passes separated by the done cycle.
- ARRAY_MAC_ACCUM_EN with a=i+1, b=j+1 -> acc_sum=36*10=360 at done; 0 after the next start accept.

Source files
------------

// File: rtl/array_mac_sequencer.sv
// Element-wise multiply sequencer: walks (i, j) row-major, reads array1[i][j] and array2[j][i],
// and streams array3[i][j] = a*b over valid/ready. Optional running sum: define ARRAY_MAC_ACCUM_EN.
module array_mac_sequencer #(
  parameter int ROW   = 8,
  parameter int COL   = 4,
  parameter int WIDTH = 10,
  localparam int RW   = $clog2(ROW),
  localparam int CW   = $clog2(COL)
`ifdef ARRAY_MAC_ACCUM_EN
  ,
  localparam int AW   = 2*WIDTH + $clog2(ROW*COL)
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  output logic               rd_en,
  output logic [RW-1:0]      rd_row,
  output logic [CW-1:0]      rd_col,
  input  logic [WIDTH-1:0]   a_data,
  input  logic [WIDTH-1:0]   b_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RW-1:0]      res_row,
  output logic [CW-1:0]      res_col,
  output logic [2*WIDTH-1:0] res_data,
  output logic               busy,
  output logic               done
`ifdef ARRAY_MAC_ACCUM_EN
  ,
  output logic [AW-1:0]      acc_sum
`endif
);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROW - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Issue counters
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  // Read in flight: operands arrive the cycle after rd_en
  logic          rd_pending;
  logic [RW-1:0] pend_row;
  logic [CW-1:0] pend_col;

  // Skid entry behind the output register
  logic               skid_valid;
  logic [RW-1:0]      skid_row;
  logic [CW-1:0]      skid_col;
  logic [2*WIDTH-1:0] skid_data;

  logic               pop;
  logic [1:0]         outstanding;
  logic               can_issue;
  logic               start_acc;
  logic               issue;
  logic               last_issue;
  logic               last_pop;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_nxt   = state;
    pop         = res_valid && res_ready;
    outstanding = {1'b0, rd_pending} + {1'b0, res_valid} + {1'b0, skid_valid};
    // A product leaving this cycle frees its slot in time for the new read's data.
    can_issue   = (outstanding - {1'b0, pop}) < 2'd2;
    start_ready = (state == IDLE);
    start_acc   = start_valid && start_ready;
    issue       = (state == RUN) && can_issue;
    last_issue  = issue && (row_q == LAST_ROW) && (col_q == LAST_COL);
    last_pop    = (state == DRAIN) && pop && (res_row == LAST_ROW) && (res_col == LAST_COL);
    product     = (2*WIDTH)'(a_data) * (2*WIDTH)'(b_data);

    unique case (state)
      IDLE:    if (start_acc)  state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_pop)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  assign rd_en  = issue;
  assign rd_row = row_q;
  assign rd_col = col_q;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      row_q <= '0;
      col_q <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last_pop;
      if (start_acc) begin
        row_q <= '0;
        col_q <= '0;
      end else if (issue) begin
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  // Read tracking, output register and skid register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      pend_row   <= '0;
      pend_col   <= '0;
      res_valid  <= 1'b0;
      res_row    <= '0;
      res_col    <= '0;
      res_data   <= '0;
      skid_valid <= 1'b0;
      skid_row   <= '0;
      skid_col   <= '0;
      skid_data  <= '0;
    end else begin
      rd_pending <= issue;
      if (issue) begin
        pend_row <= row_q;
        pend_col <= col_q;
      end

      if (!res_valid || pop) begin
        if (skid_valid) begin
          // Older skid entry moves up first; any arriving product takes its place.
          res_valid  <= 1'b1;
          res_row    <= skid_row;
          res_col    <= skid_col;
          res_data   <= skid_data;
          skid_valid <= rd_pending;
          if (rd_pending) begin
            skid_row  <= pend_row;
            skid_col  <= pend_col;
            skid_data <= product;
          end
        end else begin
          res_valid <= rd_pending;
          if (rd_pending) begin
            res_row  <= pend_row;
            res_col  <= pend_col;
            res_data <= product;
          end
        end
      end else if (rd_pending) begin
        // Output stalled: the credit rule guarantees the skid slot is free here.
        skid_valid <= 1'b1;
        skid_row   <= pend_row;
        skid_col   <= pend_col;
        skid_data  <= product;
      end
    end
  end

`ifdef ARRAY_MAC_ACCUM_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      acc_sum <= '0;
    end else if (pop) begin
      acc_sum <= acc_sum + AW'(res_data);
    end
  end
`endif

endmodule
